// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - monitors multiplexed 7-segment scan lines and decodes each digit back to hex
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int COMMON_ANODE  = 0,
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_SCANS  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              segments,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic [NUM_DIGITS-1:0]   invalid_out,
  output logic                    frame_valid,
  output logic                    update,
  output logic                    overlap_err
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(SETTLE_CYCLES + 2);
  localparam int SW = $clog2(STABLE_SCANS + 2);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{COMMON_ANODE != 0}};
  localparam logic [6:0]            SEG_OFF = {7{COMMON_ANODE != 0}};
  localparam logic [NUM_DIGITS-1:0] ONE     = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  logic [NUM_DIGITS-1:0] an_meta, an_sync, an_s;
  logic [6:0]            seg_meta, seg_sync, seg_s, seg_ref;
  logic [1:0]            state;
  logic [IW-1:0]         idx, an_idx, smp_idx;
  logic [CW-1:0]         cnt, cnt_inc;
  logic                  an_multi, an_none, cur_match;
  logic                  smp_valid, smp_blank, smp_inv;
  logic [3:0]            smp_val;

  logic [3:0]            cand_val [NUM_DIGITS];
  logic [1:0]            cand_cls [NUM_DIGITS];
  logic [SW-1:0]         cand_cnt [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] seen, seen_next;
  logic [SW-1:0]         new_cnt;
  logic                  hit, differs, commit;

  // Returns {invalid, blank, value}; the exact inverse of the gfedcba hex table.
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'h3F: decode = 6'h00;  7'h06: decode = 6'h01;  7'h5B: decode = 6'h02;  7'h4F: decode = 6'h03;
      7'h66: decode = 6'h04;  7'h6D: decode = 6'h05;  7'h7D: decode = 6'h06;  7'h07: decode = 6'h07;
      7'h7F: decode = 6'h08;  7'h6F: decode = 6'h09;  7'h77: decode = 6'h0A;  7'h7C: decode = 6'h0B;
      7'h39: decode = 6'h0C;  7'h5E: decode = 6'h0D;  7'h79: decode = 6'h0E;  7'h71: decode = 6'h0F;
      7'h00:   decode = 6'h10;
      default: decode = 6'h20;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_meta  <= AN_OFF;
      an_sync  <= AN_OFF;
      seg_meta <= SEG_OFF;
      seg_sync <= SEG_OFF;
    end else begin
      an_meta  <= an;
      an_sync  <= an_meta;
      seg_meta <= segments;
      seg_sync <= seg_meta;
    end
  end

  always_comb begin
    an_s     = an_sync ^ AN_OFF;
    seg_s    = seg_sync ^ SEG_OFF;
    an_multi = (an_s & (an_s - ONE)) != '0;
    an_none  = an_s == '0;
    an_idx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_s[i]) an_idx = IW'(i);
    end
    cur_match = an_s == (ONE << idx);
    cnt_inc   = cnt + CW'(1);
  end

  assign overlap_err = an_multi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      seg_ref   <= '0;
      cnt       <= '0;
      smp_valid <= 1'b0;
      smp_idx   <= '0;
      smp_val   <= '0;
      smp_blank <= 1'b0;
      smp_inv   <= 1'b0;
    end else begin
      smp_valid <= 1'b0;
      // Overlapping or absent selects abort whatever activation is in flight.
      if (an_multi || an_none) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            idx     <= an_idx;
            seg_ref <= seg_s;
            cnt     <= CW'(1);
            state   <= (SETTLE_CYCLES == 1) ? ST_SAMPLE : ST_SETTLE;
          end
          ST_SETTLE: begin
            if (!cur_match) begin
              state <= ST_IDLE;
            end else if (seg_s != seg_ref) begin
              seg_ref <= seg_s;
              cnt     <= CW'(1);
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == CW'(SETTLE_CYCLES)) state <= ST_SAMPLE;
            end
          end
          ST_SAMPLE: begin
            smp_valid                     <= 1'b1;
            smp_idx                       <= idx;
            {smp_inv, smp_blank, smp_val} <= decode(seg_ref);
            state                         <= ST_HOLD;
          end
          default: begin
            if (!cur_match) state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    hit = (cand_val[smp_idx] == smp_val) && (cand_cls[smp_idx] == {smp_inv, smp_blank});
    if (!hit)                                          new_cnt = SW'(1);
    else if (cand_cnt[smp_idx] == SW'(STABLE_SCANS))   new_cnt = cand_cnt[smp_idx];
    else                                               new_cnt = cand_cnt[smp_idx] + SW'(1);
    // A digit never committed always counts as different so a first "0" still commits.
    differs = !seen[smp_idx] || (digits_out[4*smp_idx +: 4] != smp_val) ||
              (blank_out[smp_idx] != smp_blank) || (invalid_out[smp_idx] != smp_inv);
    commit    = smp_valid && (new_cnt == SW'(STABLE_SCANS)) && differs;
    seen_next = seen;
    if (commit) seen_next[smp_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand_val[i] <= '0;
        cand_cls[i] <= '0;
        cand_cnt[i] <= '0;
      end
      seen        <= '0;
      digits_out  <= '0;
      blank_out   <= '0;
      invalid_out <= '0;
      frame_valid <= 1'b0;
      update      <= 1'b0;
    end else begin
      update      <= commit;
      seen        <= seen_next;
      frame_valid <= frame_valid | (&seen_next);
      if (smp_valid) begin
        cand_val[smp_idx] <= smp_val;
        cand_cls[smp_idx] <= {smp_inv, smp_blank};
        cand_cnt[smp_idx] <= new_cnt;
      end
      if (commit) begin
        digits_out[4*smp_idx +: 4] <= smp_val;
        blank_out[smp_idx]         <= smp_blank;
        invalid_out[smp_idx]       <= smp_inv;
      end
    end
  end
endmodule
